// File: rtl/des_pkg.sv
// Shared DES definitions: round-key geometry, sequencer state encoding and the
// per-round left-rotation amounts used by the key-schedule stage.
package des_pkg;

    localparam int unsigned RK_W        = 48;
    localparam int unsigned NUM_ROUNDS  = 16;
    localparam int unsigned ROUND_IDX_W = 4;
    localparam int unsigned BANK_W      = RK_W * NUM_ROUNDS;

    localparam logic [ROUND_IDX_W-1:0] LAST_ROUND = ROUND_IDX_W'(NUM_ROUNDS - 1);

    typedef logic [RK_W-1:0] rk_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } seq_state_e;

    // Two bits per round, round 1 in [1:0]: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
    localparam logic [2*NUM_ROUNDS-1:0] KEY_SHIFTS = 32'h6AA9_AAA5;

    // Rotation amount applied to C/D halves before round idx (0-based).
    function automatic logic [1:0] key_shift(input logic [ROUND_IDX_W-1:0] idx);
        return KEY_SHIFTS[2*int'(idx) +: 2];
    endfunction

endpackage

// File: rtl/des_subkey_bank.sv
// Sixteen-entry round-key register bank.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears all entries)
//   load_i    - capture all sixteen keys from keys_i
//   keys_i    - packed keys, k1 at [47:0] ... k16 at [767:720]
//   rd_idx_i  - entry selected onto rd_data_o (0 = k1)
//   rd_data_o - selected entry, read straight from the registers
module des_subkey_bank
    import des_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [BANK_W-1:0]      keys_i,
    input  logic [ROUND_IDX_W-1:0] rd_idx_i,
    output logic [RK_W-1:0]        rd_data_o
);

    rk_t bank_q [NUM_ROUNDS];

    // Whole-bank capture; the read side never sees keys_i directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
                bank_q[i] <= '0;
            end
        end else if (load_i) begin
            for (int unsigned i = 0; i < NUM_ROUNDS; i++) begin
                bank_q[i] <= keys_i[i*RK_W +: RK_W];
            end
        end
    end

    assign rd_data_o = bank_q[rd_idx_i];

endmodule

// File: rtl/des_round_key_sequencer.sv
// Captures the sixteen DES round keys on a start request and streams them one
// per accepted beat (valid/ready) to an iterative round engine, k1..k16 for
// encrypt or k16..k1 for decrypt.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - capture subkeys_in and begin streaming (taken when start_ready)
//   decrypt      - stream order, sampled with an accepted start
//   subkeys_in   - k1 at [47:0] ... k16 at [767:720]
//   start_ready  - sequencer idle and able to accept start
//   abort        - cancel streaming, return to idle without a done pulse
//   rk_valid     - rk_data/rk_round/rk_last hold a beat
//   rk_ready     - round engine accepts the current beat
//   rk_data      - current round key
//   rk_round     - stream position of rk_data, 0..15
//   rk_last      - final beat of the stream
//   done         - one-cycle pulse after the final beat transfers
module des_round_key_sequencer
    import des_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   decrypt,
    input  logic [BANK_W-1:0]      subkeys_in,
    output logic                   start_ready,
    input  logic                   abort,
    output logic                   rk_valid,
    input  logic                   rk_ready,
    output logic [RK_W-1:0]        rk_data,
    output logic [ROUND_IDX_W-1:0] rk_round,
    output logic                   rk_last,
    output logic                   done
);

    seq_state_e             state_q;
    logic [ROUND_IDX_W-1:0] cnt_q;
    logic                   dec_q;
    logic                   done_q;

    logic                   accept;
    logic [ROUND_IDX_W-1:0] rd_idx_d;
    logic [RK_W-1:0]        bank_rd;

    // start_ready must drop while rst is held, even before the first edge.
    assign start_ready = (state_q == IDLE) && !rst;
    assign accept      = start && start_ready && !abort;

    // Decrypt walks the bank backwards; 4-bit subtraction never borrows.
    assign rd_idx_d = dec_q ? ROUND_IDX_W'(LAST_ROUND - cnt_q) : cnt_q;

    des_subkey_bank u_bank (
        .clk       (clk),
        .rst       (rst),
        .load_i    (accept),
        .keys_i    (subkeys_in),
        .rd_idx_i  (rd_idx_d),
        .rd_data_o (bank_rd)
    );

    // Sequencer FSM: abort outranks both a new start and the final transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= STREAM;
                            cnt_q   <= '0;
                            dec_q   <= decrypt;
                        end
                    end
                    STREAM: begin
                        if (rk_ready) begin
                            if (cnt_q == LAST_ROUND) begin
                                state_q <= IDLE;
                                cnt_q   <= '0;
                                done_q  <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + ROUND_IDX_W'(1);
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign rk_valid = (state_q == STREAM);
    assign rk_data  = rk_valid ? bank_rd : '0;
    assign rk_round = cnt_q;
    assign rk_last  = rk_valid && (cnt_q == LAST_ROUND);
    assign done     = done_q;

endmodule
